rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter_if.sv | 17 +
 rtl/rom_arbiter.sv | 57 +++++
 tb/tb_rom_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_if.sv
// rom_arbiter_if: two-port request/response bundle plus the ROM-side read port.
interface rom_arbiter_if #(parameter int WIDTH = 32);
    logic             req0_valid, req1_valid, req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_addr, req1_addr;
    logic             resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [WIDTH-1:0] resp0_data, resp1_data;
    logic             rom_en;
    logic [WIDTH-1:0] rom_addr, rom_rd;
    modport master (
        output req0_valid, req1_valid, req0_addr, req1_addr, resp0_ready, resp1_ready, rom_rd,
        input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data, rom_en, rom_addr
    );
    modport slave (
        input  req0_valid, req1_valid, req0_addr, req1_addr, resp0_ready, resp1_ready, rom_rd,
        output req0_ready, req1_ready, resp0_valid, resp1_valid, resp0_data, resp1_data, rom_en, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// rom_arbiter: round-robin sharing of one single-cycle-latency ROM between two
// requesters, each with a one-entry response buffer.
module rom_arbiter #(parameter int WIDTH = 32) (
    input logic         clk,
    input logic         rst,
    rom_arbiter_if.slave bus
);
    typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_t;
    port_t            ptr, inflight_port;
    logic             inflight_valid;
    logic             buf0_valid, buf1_valid;
    logic [WIDTH-1:0] buf0_data, buf1_data;
    logic             elig0, elig1, grant0, grant1;
    // A port may reissue once its buffer is empty or being popped this cycle.
    always_comb begin
        elig0 = !rst && bus.req0_valid && !(inflight_valid && inflight_port == PORT0)
                && (!buf0_valid || bus.resp0_ready);
        elig1 = !rst && bus.req1_valid && !(inflight_valid && inflight_port == PORT1)
                && (!buf1_valid || bus.resp1_ready);
        grant0 = elig0 && (!elig1 || ptr == PORT0);
        grant1 = elig1 && !grant0;
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        bus.rom_en = grant0 || grant1;
        bus.rom_addr = grant0 ? bus.req0_addr : grant1 ? bus.req1_addr : '0;
        bus.resp0_valid = buf0_valid && !rst;
        bus.resp1_valid = buf1_valid && !rst;
        bus.resp0_data = rst ? '0 : buf0_data;
        bus.resp1_data = rst ? '0 : buf1_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr            <= PORT0;
            inflight_valid <= 1'b0;
            inflight_port  <= PORT0;
            buf0_valid     <= 1'b0;
            buf1_valid     <= 1'b0;
            buf0_data      <= '0;
            buf1_data      <= '0;
        end else begin
            inflight_valid <= grant0 || grant1;
            inflight_port  <= grant1 ? PORT1 : PORT0;
            if (grant0) ptr <= PORT1;
            else if (grant1) ptr <= PORT0;
            if (buf0_valid && bus.resp0_ready) buf0_valid <= 1'b0;
            if (buf1_valid && bus.resp1_ready) buf1_valid <= 1'b0;
            if (inflight_valid && inflight_port == PORT0) begin
                buf0_valid <= 1'b1;
                buf0_data  <= bus.rom_rd;
            end
            if (inflight_valid && inflight_port == PORT1) begin
                buf1_valid <= 1'b1;
                buf1_data  <= bus.rom_rd;
            end
        end
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed stimulus with a response scoreboard fed at request
// acceptance and drained by a monitor whenever a response is popped.
module tb_rom_arbiter;
    localparam int W = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    rom_arbiter_if #(.WIDTH(W)) bus();
    rom_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    int compared = 0, mismatched = 0;
    logic [W-1:0] q0[$], q1[$];
    // ROM contents: word n holds 0xC0DE0000 + n
    function automatic logic [W-1:0] word(input logic [W-1:0] a);
        return 32'hC0DE_0000 + (a >> 2);
    endfunction
    always @(posedge clk)
        if (rst) bus.rom_rd <= '0;
        else if (bus.rom_en) bus.rom_rd <= word(bus.rom_addr);
    task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.req0_valid && bus.req0_ready) q0.push_back(word(bus.req0_addr));
            if (bus.req1_valid && bus.req1_ready) q1.push_back(word(bus.req1_addr));
            if (bus.resp0_valid && bus.resp0_ready) begin
                if (q0.size() == 0) chk("resp0_unexpected", 1, 0);
                else chk("resp0_data", bus.resp0_data, q0.pop_front());
            end
            if (bus.resp1_valid && bus.resp1_ready) begin
                if (q1.size() == 0) chk("resp1_unexpected", 1, 0);
                else chk("resp1_data", bus.resp1_data, q1.pop_front());
            end
        end
    end
    task automatic next();
        @(posedge clk);
        #1;
    endtask
    initial begin
        bus.req0_valid = 1; bus.req1_valid = 1;
        bus.req0_addr = 32'h8; bus.req1_addr = 32'h4;
        bus.resp0_ready = 1; bus.resp1_ready = 1;
        // reset state with requests asserted
        repeat (2) next();
        @(negedge clk);
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_rom_en", bus.rom_en, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_resp0_valid", bus.resp0_valid, 0);
        chk("rst_resp1_valid", bus.resp1_valid, 0);
        chk("rst_resp0_data", bus.resp0_data, 0);
        // single request, first cycle after reset, 2-cycle latency
        next();
        rst = 0; bus.req1_valid = 0;
        @(negedge clk);
        chk("t1_rom_en", bus.rom_en, 1);
        chk("t1_rom_addr", bus.rom_addr, 32'h8);
        chk("t1_req0_ready", bus.req0_ready, 1);
        next();
        bus.req0_valid = 0;
        @(negedge clk);
        chk("t1_c1_resp0_valid", bus.resp0_valid, 0);
        chk("t1_c1_rom_en", bus.rom_en, 0);
        next();
        @(negedge clk);
        chk("t1_c2_resp0_valid", bus.resp0_valid, 1);
        chk("t1_c2_resp0_data", bus.resp0_data, 32'hC0DE_0002);
        // alternating grants after a fresh reset
        next();
        rst = 1;
        next();
        rst = 0;
        bus.req0_valid = 1; bus.req0_addr = 32'h0;
        bus.req1_valid = 1; bus.req1_addr = 32'h4;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_rom_en", bus.rom_en, 1);
            chk("t2_req0_ready", bus.req0_ready, (k % 2 == 0));
            chk("t2_req1_ready", bus.req1_ready, (k % 2 == 1));
            chk("t2_rom_addr", bus.rom_addr, (k % 2 == 0) ? 32'h0 : 32'h4);
            next();
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (3) next();
        // stalled port 1 must not block port 0
        bus.resp1_ready = 0;
        bus.req1_valid = 1; bus.req1_addr = 32'h14;
        @(negedge clk);
        chk("t3_fill_req1_ready", bus.req1_ready, 1);
        next();
        bus.req1_addr = 32'h18;
        bus.req0_valid = 1; bus.req0_addr = 32'h20;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t3_req1_ready", bus.req1_ready, 0);
            chk("t3_req0_ready", bus.req0_ready, (k % 2 == 1));
            if (k >= 2) begin
                chk("t3_resp1_valid", bus.resp1_valid, 1);
                chk("t3_resp1_data", bus.resp1_data, 32'hC0DE_0005);
            end
            next();
        end
        bus.resp1_ready = 1;
        @(negedge clk);
        chk("t3_release_req1_ready", bus.req1_ready, 1);
        chk("t3_release_req0_ready", bus.req0_ready, 0);
        chk("t3_release_rom_addr", bus.rom_addr, 32'h18);
        next();
        bus.req0_valid = 0; bus.req1_valid = 0;
        repeat (3) next();
        // reset discards an accepted request and restores pointer to port 0
        bus.req0_valid = 1; bus.req0_addr = 32'h0C;
        @(negedge clk);
        chk("t4_req0_ready", bus.req0_ready, 1);
        next();
        rst = 1; bus.req0_valid = 0;
        @(negedge clk);
        chk("t4_rst_rom_en", bus.rom_en, 0);
        chk("t4_rst_resp0_valid", bus.resp0_valid, 0);
        next();
        rst = 0;
        bus.req0_valid = 1; bus.req0_addr = 32'h10;
        bus.req1_valid = 1; bus.req1_addr = 32'h13;
        @(negedge clk);
        chk("t4_n2_resp0_valid", bus.resp0_valid, 0);
        chk("t4_ptr_req0_ready", bus.req0_ready, 1);
        chk("t4_ptr_req1_ready", bus.req1_ready, 0);
        chk("t5_rom_addr0", bus.rom_addr, 32'h10);
        next();
        @(negedge clk);
        chk("t5_req1_ready", bus.req1_ready, 1);
        chk("t5_rom_word1", bus.rom_addr >> 2, 32'h4);
        next();
        bus.req0_valid = 0; bus.req1_valid = 0;
        @(negedge clk);
        chk("t5_resp0_data", bus.resp0_data, 32'hC0DE_0004);
        next();
        @(negedge clk);
        chk("t5_resp1_data", bus.resp1_data, 32'hC0DE_0004);
        repeat (3) next();
        @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
